// File: rtl/fifo_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ctl_if
//  Purpose  : Bundles the enqueue/dequeue/control strobes and the status and
//             data outputs of fifo_ctl. The producer/consumer side uses the
//             master modport; the FIFO itself uses the slave modport.
//  Revision : 1.0  initial release
// ============================================================================
interface fifo_ctl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
);
  localparam int c_AW = $clog2(DEPTH);

  logic             enq;
  logic [WIDTH-1:0] din;
  logic             deq;
  logic             flush;
  logic             clr_err;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [c_AW:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output enq, din, deq, flush, clr_err,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  enq, din, deq, flush, clr_err,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/fifo_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ctl
//  Purpose  : Single-clock circular-buffer FIFO with occupancy count,
//             almost-full/almost-empty thresholds, sticky overflow/underflow
//             flags and synchronous flush.
//  Options  : FIFO_FWFT_EN defined   -> first-word-fall-through read port
//             FIFO_FWFT_EN undefined -> dout registered on accepted dequeue
//  Revision : 1.0  initial release
// ============================================================================
module fifo_ctl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 64,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  fifo_ctl_if.slave  bus
);

  localparam int            c_AW    = $clog2(DEPTH);
  localparam logic [c_AW:0] c_DEPTH = (c_AW + 1)'(DEPTH);
  localparam logic [c_AW:0] c_AF    = (c_AW + 1)'(AF_THRESH);
  localparam logic [c_AW:0] c_AE    = (c_AW + 1)'(AE_THRESH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_AW-1:0]  wp_q, wp_d;
  logic [c_AW-1:0]  rp_q, rp_d;
  logic [c_AW:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic w_full;
  logic w_empty;
  logic w_acc_enq;
  logic w_acc_deq;

  // Status decodes straight from the registered occupancy
  assign w_full    = (count_q == c_DEPTH);
  assign w_empty   = (count_q == '0);
  // Acceptance uses pre-edge state; flush suppresses both sides
  assign w_acc_enq = bus.enq && !w_full  && !bus.flush;
  assign w_acc_deq = bus.deq && !w_empty && !bus.flush;

  // Next-state for pointers, occupancy and sticky error flags
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (bus.clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (bus.flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      // A new error event wins over a coincident clear
      if (bus.enq && w_full)  ovf_d = 1'b1;
      if (bus.deq && w_empty) udf_d = 1'b1;
      if (w_acc_enq) wp_d = wp_q + 1'b1;
      if (w_acc_deq) rp_d = rp_q + 1'b1;
      case ({w_acc_enq, w_acc_deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (w_acc_enq) mem_q[wp_q] <= bus.din;
  end

`ifdef FIFO_FWFT_EN
  // Head entry is presented combinationally; zero when nothing is stored
  assign bus.dout = w_empty ? '0 : mem_q[rp_q];
`else
  logic [WIDTH-1:0] dout_q, dout_d;

  // Capture the head entry only on an accepted dequeue, clear on flush
  always_comb begin
    dout_d = dout_q;
    if (bus.flush)      dout_d = '0;
    else if (w_acc_deq) dout_d = mem_q[rp_q];
  end

  // Read data register with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dout_q <= '0;
    else          dout_q <= dout_d;
  end

  assign bus.dout = dout_q;
`endif

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (count_q >= c_AF);
  assign bus.almost_empty = (count_q <= c_AE);
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule
`default_nettype wire
